// File: rtl/sobel_gradient.sv
// Three-stage Sobel gradient pipeline: partial sums, absolute values, then a saturated or
// thresholded edge pixel, with a per-frame edge counter and an end-of-burst pulse.
module sobel_gradient #(
    parameter int unsigned THRESHOLD  = 128,
    parameter int unsigned BINARY_OUT = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       d0_i,
    input  logic [7:0]       d1_i,
    input  logic [7:0]       d2_i,
    input  logic [7:0]       d3_i,
    input  logic [7:0]       d4_i,
    input  logic [7:0]       d5_i,
    input  logic [7:0]       d6_i,
    input  logic [7:0]       d7_i,
    input  logic [7:0]       d8_i,
    input  logic             done_i,
    output logic [7:0]       edge_o,
    output logic             done_o,
    output logic [CNT_W-1:0] edge_cnt_o,
    output logic             frame_end_o
);

    logic [9:0]       w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic [9:0]       r_gx_pos, r_gx_neg, r_gy_pos, r_gy_neg;
    logic [9:0]       w_abs_gx, w_abs_gy;
    logic [9:0]       r_abs_gx, r_abs_gy;
    logic [10:0]      w_mag;
    logic [7:0]       w_sat;
    logic             w_is_edge;
    logic [7:0]       w_edge_val;
    logic [2:0]       r_vld;
    logic [7:0]       r_edge;
    logic             r_frame_end;
    logic             r_done_q;
    logic             w_rise;
    logic [CNT_W-1:0] r_cnt;

    // Center pixel d4 has zero weight in both kernels.
    logic [7:0] w_unused_d4;
    assign w_unused_d4 = d4_i;

    always_comb begin
        w_gx_pos = {2'b00, d2_i} + {1'b0, d5_i, 1'b0} + {2'b00, d8_i};
        w_gx_neg = {2'b00, d0_i} + {1'b0, d3_i, 1'b0} + {2'b00, d6_i};
        w_gy_pos = {2'b00, d6_i} + {1'b0, d7_i, 1'b0} + {2'b00, d8_i};
        w_gy_neg = {2'b00, d0_i} + {1'b0, d1_i, 1'b0} + {2'b00, d2_i};
    end

    always_comb begin
        w_abs_gx = (r_gx_pos >= r_gx_neg) ? (r_gx_pos - r_gx_neg) : (r_gx_neg - r_gx_pos);
        w_abs_gy = (r_gy_pos >= r_gy_neg) ? (r_gy_pos - r_gy_neg) : (r_gy_neg - r_gy_pos);
    end

    always_comb begin
        w_mag      = {1'b0, r_abs_gx} + {1'b0, r_abs_gy};
        w_sat      = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];
        w_is_edge  = (32'(w_sat) >= THRESHOLD);
        w_edge_val = (BINARY_OUT != 0) ? (w_is_edge ? 8'hFF : 8'h00) : w_sat;
        w_rise     = done_i & ~r_done_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gx_pos <= '0;
            r_gx_neg <= '0;
            r_gy_pos <= '0;
            r_gy_neg <= '0;
            r_abs_gx <= '0;
            r_abs_gy <= '0;
        end else begin
            r_gx_pos <= w_gx_pos;
            r_gx_neg <= w_gx_neg;
            r_gy_pos <= w_gy_pos;
            r_gy_neg <= w_gy_neg;
            r_abs_gx <= w_abs_gx;
            r_abs_gy <= w_abs_gy;
        end
    end

    // r_vld[1] marks a valid pixel in S2, i.e. the one being loaded into S3 this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld       <= '0;
            r_edge      <= '0;
            r_frame_end <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_vld       <= {r_vld[1:0], done_i};
            r_edge      <= r_vld[1] ? w_edge_val : 8'h00;
            r_frame_end <= r_vld[2] & ~r_vld[1];
            r_done_q    <= done_i;
        end
    end

    // Frame start clear takes priority over a draining edge pixel from the previous frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= '0;
        end else if (r_vld[1] && w_is_edge && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign edge_o      = r_edge;
    assign done_o      = r_vld[2];
    assign edge_cnt_o  = r_cnt;
    assign frame_end_o = r_frame_end;

endmodule

// File: tb/tb_sobel_gradient.sv
// Bench for sobel_gradient: three parameterisations driven in parallel, checked against a
// cycle-level reference model and a table of hand-computed window results.
module tb_sobel_gradient;

    typedef logic [8:0][7:0] win_t;
    typedef struct { win_t w; int ea; int eb; int ca; } vec_t;
    typedef struct { logic v; int mag; } samp_t;

    logic        clk;
    logic        rst;
    win_t        win;
    logic        din;
    logic [7:0]  edge_a, edge_b, edge_c;
    logic        done_a, done_b, done_c;
    logic [15:0] cnt_a, cnt_b;
    logic [2:0]  cnt_c;
    logic        fe_a, fe_b, fe_c;

    int    checks;
    int    errors;
    int    fe_seen;
    int    thr_k  [3] = '{128, 40, 0};
    int    bin_k  [3] = '{0, 1, 0};
    int    max_k  [3] = '{65535, 65535, 7};
    samp_t hq[$];
    int    m_cnt  [3];
    int    e_edge [3];
    logic  e_done;
    logic  e_fe;

    sobel_gradient #(.THRESHOLD(128), .BINARY_OUT(0), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst),
        .d0_i(win[0]), .d1_i(win[1]), .d2_i(win[2]), .d3_i(win[3]), .d4_i(win[4]),
        .d5_i(win[5]), .d6_i(win[6]), .d7_i(win[7]), .d8_i(win[8]),
        .done_i(din), .edge_o(edge_a), .done_o(done_a), .edge_cnt_o(cnt_a),
        .frame_end_o(fe_a)
    );

    sobel_gradient #(.THRESHOLD(40), .BINARY_OUT(1), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst),
        .d0_i(win[0]), .d1_i(win[1]), .d2_i(win[2]), .d3_i(win[3]), .d4_i(win[4]),
        .d5_i(win[5]), .d6_i(win[6]), .d7_i(win[7]), .d8_i(win[8]),
        .done_i(din), .edge_o(edge_b), .done_o(done_b), .edge_cnt_o(cnt_b),
        .frame_end_o(fe_b)
    );

    sobel_gradient #(.THRESHOLD(0), .BINARY_OUT(0), .CNT_W(3)) u_c (
        .clk(clk), .rst(rst),
        .d0_i(win[0]), .d1_i(win[1]), .d2_i(win[2]), .d3_i(win[3]), .d4_i(win[4]),
        .d5_i(win[5]), .d6_i(win[6]), .d7_i(win[7]), .d8_i(win[8]),
        .done_i(din), .edge_o(edge_c), .done_o(done_c), .edge_cnt_o(cnt_c),
        .frame_end_o(fe_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic win_t mk(input int d0, input int d1, input int d2, input int d3,
                                input int d4, input int d5, input int d6, input int d7,
                                input int d8);
        win_t w;
        w[0] = 8'(d0); w[1] = 8'(d1); w[2] = 8'(d2);
        w[3] = 8'(d3); w[4] = 8'(d4); w[5] = 8'(d5);
        w[6] = 8'(d6); w[7] = 8'(d7); w[8] = 8'(d8);
        return w;
    endfunction

    function automatic win_t rnd_win();
        win_t w;
        int   lim;
        lim = ($urandom_range(0, 1) == 0) ? 40 : 255;
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, lim));
        return w;
    endfunction

    function automatic int sobel_mag(input win_t w);
        int d [9];
        int gx, gy;
        for (int i = 0; i < 9; i++) d[i] = int'(w[i]);
        gx = (d[2] + 2 * d[5] + d[8]) - (d[0] + 2 * d[3] + d[6]);
        gy = (d[6] + 2 * d[7] + d[8]) - (d[0] + 2 * d[1] + d[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return gx + gy;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp_t z;
        z.v = 1'b0;
        z.mag = 0;
        hq.delete();
        repeat (4) hq.push_back(z);
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]  = 0;
            e_edge[k] = 0;
        end
        e_done = 1'b0;
        e_fe   = 1'b0;
    endtask

    // One rising edge: hq[3] sampled now, hq[1] is the pixel now shown at the output.
    task automatic model_edge(input win_t w, input logic v);
        samp_t s;
        int    sat;
        logic  rise;
        s.v   = v;
        s.mag = sobel_mag(w);
        hq.push_back(s);
        void'(hq.pop_front());
        rise   = v && !hq[2].v;
        e_done = hq[1].v;
        e_fe   = hq[0].v && !hq[1].v;
        sat    = (hq[1].mag > 255) ? 255 : hq[1].mag;
        for (int k = 0; k < 3; k++) begin
            if (!e_done) e_edge[k] = 0;
            else if (bin_k[k] != 0) e_edge[k] = (sat >= thr_k[k]) ? 255 : 0;
            else e_edge[k] = sat;
            if (rise) m_cnt[k] = 0;
            else if (e_done && sat >= thr_k[k] && m_cnt[k] < max_k[k]) m_cnt[k]++;
        end
    endtask

    task automatic check_all();
        chk("done_a", int'(done_a), int'(e_done));
        chk("done_b", int'(done_b), int'(e_done));
        chk("done_c", int'(done_c), int'(e_done));
        chk("edge_a", int'(edge_a), e_edge[0]);
        chk("edge_b", int'(edge_b), e_edge[1]);
        chk("edge_c", int'(edge_c), e_edge[2]);
        chk("cnt_a", int'(cnt_a), m_cnt[0]);
        chk("cnt_b", int'(cnt_b), m_cnt[1]);
        chk("cnt_c", int'(cnt_c), m_cnt[2]);
        chk("fe_a", int'(fe_a), int'(e_fe));
        chk("fe_c", int'(fe_c), int'(e_fe));
        if (fe_a) fe_seen++;
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic step(input win_t w, input logic v);
        win = w;
        din = v;
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge(w, v);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(rnd_win(), 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_done"}, int'(done_a), 0);
        chk({tag, "_edge"}, int'(edge_a), 0);
        chk({tag, "_cnt"}, int'(cnt_a), 0);
        chk({tag, "_fe"}, int'(fe_a), 0);
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(rnd_win(), 1'b1);
        rst = 1'b1;
    endtask

    vec_t tbl [9];
    int   fe_at;

    initial begin
        checks  = 0;
        errors  = 0;
        fe_seen = 0;
        win     = '0;
        din     = 1'b0;
        rst     = 1'b1;
        model_reset();

        tbl[0] = '{mk(77, 77, 77, 77, 77, 77, 77, 77, 77), 0, 0, 0};
        tbl[1] = '{mk(0, 5, 10, 0, 5, 10, 0, 5, 10), 40, 255, 0};
        tbl[2] = '{mk(0, 5, 9, 0, 5, 9, 0, 5, 9), 36, 0, 0};
        tbl[3] = '{mk(0, 0, 200, 0, 0, 200, 0, 0, 200), 255, 255, 1};
        tbl[4] = '{mk(255, 0, 0, 0, 0, 0, 0, 0, 0), 255, 255, 1};
        tbl[5] = '{mk(0, 0, 0, 0, 0, 0, 50, 50, 50), 200, 255, 1};
        tbl[6] = '{mk(0, 0, 0, 0, 0, 64, 0, 0, 0), 128, 255, 1};
        tbl[7] = '{mk(0, 0, 0, 0, 0, 63, 0, 0, 0), 126, 255, 0};
        tbl[8] = '{mk(0, 0, 0, 0, 0, 127, 0, 0, 0), 254, 255, 1};

        // Reset held with valid traffic present: everything must stay at zero.
        #3 rst = 1'b0;
        #1;
        chk("rst_async_done", int'(done_a), 0);
        chk("rst_async_cnt", int'(cnt_a), 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) step(rnd_win(), 1'b1);
        rst = 1'b1;

        // First accepted window shows up on the third following edge.
        step(rnd_win(), 1'b1);
        chk("lat_edge1", int'(done_a), 0);
        step(rnd_win(), 1'b1);
        chk("lat_edge2", int'(done_a), 0);
        step(rnd_win(), 1'b1);
        chk("lat_edge3", int'(done_a), 1);
        idle(4);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].w, 1'b1);
            idle(2);
            chk($sformatf("tbl%0d_edge_a", i), int'(edge_a), tbl[i].ea);
            chk($sformatf("tbl%0d_edge_b", i), int'(edge_b), tbl[i].eb);
            chk($sformatf("tbl%0d_cnt_a", i), int'(cnt_a), tbl[i].ca);
            idle(2);
        end

        // Flat frame of five pixels: no edges, exactly one frame end three cycles after.
        fe_seen = 0;
        for (int i = 0; i < 5; i++) step(tbl[0].w, 1'b1);
        fe_at = -1;
        for (int i = 1; i <= 8; i++) begin
            step(rnd_win(), 1'b0);
            if (fe_a && fe_at < 0) fe_at = i;
        end
        chk("flat_fe_count", fe_seen, 1);
        chk("flat_fe_pos", fe_at, 3);
        chk("flat_cnt", int'(cnt_a), 0);

        // Strong edge then diagonal in one burst: two counted edges.
        step(tbl[3].w, 1'b1);
        step(tbl[4].w, 1'b1);
        idle(4);
        chk("strong_cnt", int'(cnt_a), 2);

        // Two frames with a 2-cycle gap: count 4, clear on the new frame, end at 1.
        fe_seen = 0;
        for (int i = 0; i < 4; i++) step(tbl[3].w, 1'b1);
        idle(2);
        chk("fr1_cnt", int'(cnt_a), 4);
        step(tbl[4].w, 1'b1);
        chk("fr2_clear", int'(cnt_a), 0);
        idle(4);
        chk("fr2_cnt", int'(cnt_a), 1);
        chk("fr_fe_count", fe_seen, 2);

        // Threshold 0 counts every pixel; the 3-bit counter must stop at 7.
        for (int i = 0; i < 10; i++) step(rnd_win(), 1'b1);
        idle(3);
        chk("sat_cnt_c", int'(cnt_c), 7);
        chk("sat_cnt_a_ref", int'(cnt_a), m_cnt[0]);

        for (int i = 0; i < 400; i++) begin
            step(rnd_win(), ($urandom_range(0, 3) != 0));
            if (i == 200) async_reset("midrst");
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
